geofence_ap_sort: RTL and testbench
===================================

// Module: geofence_ap_sort
// PURPOSE
//  Front-end ordering stage of the geofence datapath. Captures one object point and NUM_AP antenna points.
//  Sorts antennas 1..NUM_AP-1 by angle around antenna 0 (signed cross product).
//  Streams the object, then the angle-ordered polygon, to the downstream inside-test stage over valid/ready.
// PARAMETERS
//  COORD_W  10  unsigned coordinate width of X/Y
//  NUM_AP   6   antennas per object (>=3); compare count C = (NUM_AP-2)*(NUM_AP-1)/2 (=10)
// PORTS
//  clk        in   1        clock, all state on rising edge
//  reset      in   1        synchronous, active-high
//  in_valid   in   1        X/Y beat present
//  in_ready   out  1        beat accepted when in_valid&&in_ready
//  X          in   COORD_W  point x; beat 0 = object, beats 1..NUM_AP = A0..A(NUM_AP-1)
//  Y          in   COORD_W  point y
//  out_valid  out  1        output beat present
//  out_ready  in   1        downstream accepts beat
//  out_x      out  COORD_W  object, then sorted A0..A(NUM_AP-1)
//  out_y      out  COORD_W
//  out_last   out  1        high on final (NUM_AP+1-th) output beat
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, out_last=0, out_x=out_y=0, counters=0. Reset in any state aborts.
//    Partial set is discarded; no output beats follow.
//  FSM IDLE/LOAD -> SORT -> EMIT -> IDLE. in_ready=1 only in IDLE/LOAD; in_valid otherwise ignored.
//  LOAD: beat k stored at slot k (0=obj). Capture of beat NUM_AP (last) -> SORT next cycle; no gap needed between sets.
//  SORT: bubble sort of slots A1..A(NUM_AP-1), pivot A0 fixed.
//    One compare-swap per cycle; pass p=0..NUM_AP-3 compares j,j+1 for j=1..NUM_AP-2-p.
//  Compare: v=A-A0 as signed (COORD_W+1)-bit; cr = vj.x*vj1.y - vj.y*vj1.x, signed 2*COORD_W+3 bits, no overflow.
//    Swap iff cr<0. cr==0 (collinear) -> no swap, so input order is stable.
//    Result: counter-clockwise in Y-up coordinates.
//  Latency: out_valid first high C+1 cycles after the edge capturing the last input beat (11 at defaults).
//  EMIT: out_* registered; beat advances only on out_valid&&out_ready.
//    While out_ready=0, out_x/out_y/out_last hold.
//  Last beat accepted -> IDLE, in_ready=1 next cycle. out_valid low in IDLE/LOAD/SORT.
//  Coordinates 0 and 2^COORD_W-1 are legal. Full-range deltas must not overflow.
// CONFIGURATION
//  GEOFENCE_CROSS_PIPE_EN defined: cross product registered, compare takes 2 cycles (compute, swap).
//    Latency 2*C+1 (21). Output order is identical.
//  Undefined: single-cycle combinational compare, latency C+1.
// STRUCTURE
//  geofence_pkg: point_t struct {x,y}, COORD_W, NUM_AP, CROSS_W, state enum.
//  Sub-module geofence_cross: inputs pivot, a, b (point_t); output cross sign (neg, zero).
//    Combinational; reusable by the inside-test stage.
//  Top holds point buffer, pass/index counters, FSM, output mux.
// TESTING
//  1 Hexagon, scrambled. Obj (15,10); A0..A5 = (0,10),(20,20),(10,0),(30,10),(10,20),(20,0).
//    -> out: (15,10),(0,10),(10,0),(20,0),(30,10),(20,20),(10,20). out_last on beat 7, first out_valid at cycle 11.
//  2 Already sorted: feed scenario 1 output order -> identical order returned, no swap observed.
//  3 Collinear: A0=(0,0), A1=(20,20), A2=(10,10), rest (30,0),(0,30),(40,40).
//    -> (20,20) before (10,10) (stable), (40,40) kept after.
//  4 Backpressure: out_ready=0 for 3 cycles at beat 3 -> out_x/out_y held. All 7 beats delivered once; in_ready low until done.
//  5 Reset during SORT cycle 4 -> out_valid=0, in_ready=1 next cycle. Next full set sorts correctly.
//  6 Extremes: A0=(0,0), others at (1023,0),(1023,1023),(0,1023),(1023,511),(511,1023).
//    -> CCW order, no overflow; repeat with GEOFENCE_CROSS_PIPE_EN -> same order, latency 21.

Source files
------------

// File: rtl/geofence_pkg.sv
// Shared types and sizing for the geofence datapath.
// Point format, counter widths and the ordering-stage FSM encoding.
package geofence_pkg;
    localparam int COORD_W = 10;
    localparam int NUM_AP  = 6;
    localparam int NUM_PT  = NUM_AP + 1;
    localparam int CROSS_W = 2 * COORD_W + 3;
    localparam int IDX_W   = $clog2(NUM_PT + 1);

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } point_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SORT,
        EMIT
    } state_t;
endpackage

// File: rtl/geofence_cross.sv
// Sign of the cross product (a - pivot) x (b - pivot).
// Purely combinational so the inside-test stage can reuse it.
module geofence_cross
    import geofence_pkg::*;
(
    input  point_t pivot,
    input  point_t a,
    input  point_t b,
    output logic   neg,
    output logic   zero
);
    logic signed [COORD_W:0]    ax, ay, bx, by;
    logic signed [CROSS_W-1:0]  cr;

    assign ax = $signed({1'b0, a.x}) - $signed({1'b0, pivot.x});
    assign ay = $signed({1'b0, a.y}) - $signed({1'b0, pivot.y});
    assign bx = $signed({1'b0, b.x}) - $signed({1'b0, pivot.x});
    assign by = $signed({1'b0, b.y}) - $signed({1'b0, pivot.y});

    // Operands widened first so full-range deltas never overflow.
    assign cr = CROSS_W'(ax) * CROSS_W'(by) - CROSS_W'(ay) * CROSS_W'(bx);

    assign neg  = cr[CROSS_W-1];
    assign zero = (cr == '0);
endmodule

// File: rtl/geofence_ap_sort.sv
// Captures object + antennas, bubble-sorts antennas CCW around A0, streams them out.
// Define GEOFENCE_CROSS_PIPE_EN to register the cross sign (2-cycle compare).
module geofence_ap_sort
    import geofence_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COORD_W-1:0] X,
    input  logic [COORD_W-1:0] Y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic               out_last
);
    localparam logic [IDX_W-1:0] ONE       = IDX_W'(1);
    localparam logic [IDX_W-1:0] TWO       = IDX_W'(2);
    localparam logic [IDX_W-1:0] LAST_LD   = IDX_W'(NUM_AP);
    localparam logic [IDX_W-1:0] LAST_PASS = IDX_W'(NUM_AP - 3);
    localparam logic [IDX_W-1:0] J_TOP     = IDX_W'(NUM_AP - 2);

    state_t           state, state_nxt;
    point_t           pts [NUM_PT];
    logic [IDX_W-1:0] ld_cnt, pass, j, eidx;
    logic [IDX_W-1:0] a_idx, b_idx;
    point_t           a_pt, b_pt;
    logic             neg_c, zero_c;
    logic             fire_in, fire_out, load_done;
    logic             step, swap, pass_end, sort_last;

    // Slot 0 is the object, slot 1 the pivot A0, slot k+1 antenna Ak.
    assign a_idx = j + ONE;
    assign b_idx = j + TWO;
    assign a_pt  = pts[a_idx];
    assign b_pt  = pts[b_idx];

    geofence_cross u_cross (
        .pivot (pts[1]),
        .a     (a_pt),
        .b     (b_pt),
        .neg   (neg_c),
        .zero  (zero_c)
    );

`ifdef GEOFENCE_CROSS_PIPE_EN
    logic phase, neg_q, zero_q;
    assign step = (state == SORT) && phase;
    assign swap = neg_q && !zero_q;
`else
    assign step = (state == SORT);
    assign swap = neg_c && !zero_c;
`endif

    assign in_ready  = (state == IDLE) || (state == LOAD);
    assign fire_in   = in_valid && in_ready;
    assign fire_out  = out_valid && out_ready;
    assign load_done = fire_in && (ld_cnt == LAST_LD);
    assign pass_end  = (j == J_TOP - pass);
    assign sort_last = step && pass_end && (pass == LAST_PASS);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (fire_in) state_nxt = LOAD;
            LOAD:    if (load_done) state_nxt = SORT;
            SORT:    if (sort_last) state_nxt = EMIT;
            EMIT:    if (fire_out && out_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ld_cnt    <= '0;
            pass      <= '0;
            j         <= '0;
            eidx      <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
`ifdef GEOFENCE_CROSS_PIPE_EN
            phase     <= 1'b0;
`endif
        end else begin
            if (fire_in) begin
                pts[ld_cnt] <= '{x: X, y: Y};
                ld_cnt      <= load_done ? '0 : ld_cnt + ONE;
            end
            if (load_done) begin
                pass <= '0;
                j    <= ONE;
            end
`ifdef GEOFENCE_CROSS_PIPE_EN
            if (state == SORT) begin
                phase  <= !phase;
                neg_q  <= neg_c;
                zero_q <= zero_c;
            end
`endif
            if (step) begin
                if (swap) begin
                    pts[a_idx] <= b_pt;
                    pts[b_idx] <= a_pt;
                end
                if (pass_end) begin
                    pass <= pass + ONE;
                    j    <= ONE;
                end else begin
                    j <= j + ONE;
                end
            end
            // First EMIT cycle only primes the output register.
            if (state == EMIT) begin
                if (!out_valid) begin
                    out_valid <= 1'b1;
                    out_x     <= pts[0].x;
                    out_y     <= pts[0].y;
                    out_last  <= 1'b0;
                    eidx      <= ONE;
                end else if (out_ready) begin
                    if (out_last) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        eidx      <= '0;
                    end else begin
                        out_x    <= pts[eidx].x;
                        out_y    <= pts[eidx].y;
                        out_last <= (eidx == LAST_LD);
                        eidx     <= eidx + ONE;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_geofence_ap_sort.sv
// Randomized bench for geofence_ap_sort with an in-bench angular-sort model.
// Honours GEOFENCE_CROSS_PIPE_EN for the expected latency.
module tb_geofence_ap_sort;
    import geofence_pkg::*;

    localparam int C = (NUM_AP - 2) * (NUM_AP - 1) / 2;
`ifdef GEOFENCE_CROSS_PIPE_EN
    localparam int LAT = 2 * C + 1;
`else
    localparam int LAT = C + 1;
`endif

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [COORD_W-1:0] X = '0;
    logic [COORD_W-1:0] Y = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [COORD_W-1:0] out_x, out_y;
    logic               out_last;

    geofence_ap_sort dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X         (X),
        .Y         (Y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s", name);
    endtask

    // Reference: cross product from plain integer arithmetic.
    function automatic longint crs(input int px, py, ax, ay, bx, by);
        return longint'(ax - px) * longint'(by - py)
             - longint'(ay - py) * longint'(bx - px);
    endfunction

    // Bubble sort of antennas A1..A(N-1) around A0; ties keep input order.
    function automatic void model_sort(input int ix[NUM_PT], input int iy[NUM_PT],
                                       output int ox[NUM_PT], output int oy[NUM_PT]);
        int t;
        ox = ix;
        oy = iy;
        for (int p = 0; p <= NUM_AP - 3; p++) begin
            for (int k = 1; k <= NUM_AP - 2 - p; k++) begin
                if (crs(ox[1], oy[1], ox[k+1], oy[k+1], ox[k+2], oy[k+2]) < 0) begin
                    t = ox[k+1]; ox[k+1] = ox[k+2]; ox[k+2] = t;
                    t = oy[k+1]; oy[k+1] = oy[k+2]; oy[k+2] = t;
                end
            end
        end
    endfunction

    int qx[$], qy[$];
    bit ql[$];
    int in_x[NUM_PT], in_y[NUM_PT];
    int beat_n = 0;
    int cyc = 0;
    int cap_cyc = 0;
    bit wait_first = 0;

    // Input capture and scoreboard bookkeeping at the active edge.
    always @(posedge clk) begin
        int ex[NUM_PT], ey[NUM_PT];
        cyc++;
        if (reset) begin
            beat_n = 0;
            qx.delete(); qy.delete(); ql.delete();
            wait_first = 0;
        end else begin
            if (out_valid && out_ready && qx.size() > 0) begin
                void'(qx.pop_front()); void'(qy.pop_front()); void'(ql.pop_front());
            end
            if (in_valid && in_ready) begin
                in_x[beat_n] = int'(X);
                in_y[beat_n] = int'(Y);
                beat_n++;
                if (beat_n == NUM_PT) begin
                    model_sort(in_x, in_y, ex, ey);
                    for (int k = 0; k < NUM_PT; k++) begin
                        qx.push_back(ex[k]);
                        qy.push_back(ey[k]);
                        ql.push_back(k == NUM_PT - 1);
                    end
                    beat_n = 0;
                    cap_cyc = cyc;
                    wait_first = 1;
                end
            end
        end
    end

    int hx = 0, hy = 0, hl = 0;
    bit hold_pend = 0;

    // Compare process: every cycle the output is meaningful.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid) begin
                check("in_ready_emit", int'(in_ready), 0);
                if (qx.size() == 0) fail_now("unexpected_out_beat");
                else begin
                    check("out_x", int'(out_x), qx[0]);
                    check("out_y", int'(out_y), qy[0]);
                    check("out_last", int'(out_last), int'(ql[0]));
                end
                if (hold_pend) begin
                    check("hold_x", int'(out_x), hx);
                    check("hold_y", int'(out_y), hy);
                    check("hold_last", int'(out_last), hl);
                end
                if (wait_first) begin
                    check("latency", cyc - cap_cyc, LAT);
                    wait_first = 0;
                end
            end else if (wait_first) begin
                check("in_ready_sort", int'(in_ready), 0);
                if (cyc - cap_cyc > LAT) begin
                    fail_now("latency_expired");
                    wait_first = 0;
                end
            end
            hold_pend = out_valid && !out_ready;
            hx = int'(out_x); hy = int'(out_y); hl = int'(out_last);
        end else begin
            hold_pend = 0;
        end
    end

    // Downstream ready: 0 always, 1 random, 2 one 3-cycle stall on beat 3.
    int rdy_mode = 0;
    int acc_n = 0;
    bit stalled = 0;
    int stall_left = 0;
    always @(posedge clk) begin
        if (out_valid && out_ready) acc_n++;
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(3) != 0);
            default: begin
                if (acc_n == 2 && !stalled) begin
                    stalled = 1;
                    stall_left = 3;
                end
                out_ready = (stall_left == 0);
                if (stall_left > 0) stall_left--;
            end
        endcase
    end

    task automatic send_set(input int xs[NUM_PT], input int ys[NUM_PT], input bit gaps);
        int t;
        for (int k = 0; k < NUM_PT; k++) begin
            if (gaps && $urandom_range(2) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            X = COORD_W'(xs[k]);
            Y = COORD_W'(ys[k]);
            t = 0;
            while (!in_ready && t < 300) begin
                @(posedge clk); #1;
                t++;
            end
            if (t >= 300) fail_now("in_ready_timeout");
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while ((qx.size() > 0 || wait_first) && t < 400) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (t >= 400) fail_now("drain_timeout");
    endtask

    task automatic check_model(input string name, input int ix[NUM_PT], input int iy[NUM_PT],
                               input int lx[NUM_PT], input int ly[NUM_PT]);
        int ox[NUM_PT], oy[NUM_PT];
        model_sort(ix, iy, ox, oy);
        for (int k = 0; k < NUM_PT; k++) begin
            check({name, "_x"}, ox[k], lx[k]);
            check({name, "_y"}, oy[k], ly[k]);
        end
    endtask

    function automatic int rnd_coord();
        int sel = $urandom_range(5);
        if (sel == 0) return 0;
        if (sel == 1) return 1023;
        if (sel == 2) return 511;
        return $urandom_range(1023);
    endfunction

    initial begin
        int hex_x[NUM_PT] = '{15, 0, 20, 10, 30, 10, 20};
        int hex_y[NUM_PT] = '{10, 10, 20, 0, 10, 20, 0};
        int srt_x[NUM_PT] = '{15, 0, 10, 20, 30, 20, 10};
        int srt_y[NUM_PT] = '{10, 10, 0, 0, 10, 20, 20};
        int col_x[NUM_PT] = '{5, 0, 20, 10, 30, 0, 40};
        int col_y[NUM_PT] = '{5, 0, 20, 10, 0, 30, 40};
        int colo_x[NUM_PT] = '{5, 0, 30, 20, 10, 40, 0};
        int colo_y[NUM_PT] = '{5, 0, 0, 20, 10, 40, 30};
        int ext_x[NUM_PT] = '{100, 0, 1023, 1023, 0, 1023, 511};
        int ext_y[NUM_PT] = '{100, 0, 0, 1023, 1023, 511, 1023};
        int exto_x[NUM_PT] = '{100, 0, 1023, 1023, 1023, 511, 0};
        int exto_y[NUM_PT] = '{100, 0, 0, 511, 1023, 1023, 1023};
        int rx[NUM_PT], ry[NUM_PT];

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_out_x", int'(out_x), 0);
        check("rst_out_y", int'(out_y), 0);

        // Pin the model against hand-derived orders.
        check_model("model_hex", hex_x, hex_y, srt_x, srt_y);
        check_model("model_sorted", srt_x, srt_y, srt_x, srt_y);
        check_model("model_collinear", col_x, col_y, colo_x, colo_y);
        check_model("model_extreme", ext_x, ext_y, exto_x, exto_y);

        send_set(hex_x, hex_y, 0);
        wait_done();
        send_set(srt_x, srt_y, 0);
        wait_done();
        send_set(col_x, col_y, 0);
        wait_done();

        acc_n = 0; stalled = 0; rdy_mode = 2;
        send_set(hex_x, hex_y, 0);
        wait_done();
        check("backpressure_beats", acc_n, NUM_PT);
        rdy_mode = 0;

        send_set(ext_x, ext_y, 0);
        wait_done();

        // Abort mid-sort, then a clean set must still sort correctly.
        send_set(hex_x, hex_y, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_in_ready", int'(in_ready), 1);
        check("abort_out_x", int'(out_x), 0);
        repeat (LAT + 3) @(posedge clk);
        #1;
        check("abort_no_output", int'(out_valid), 0);
        send_set(ext_x, ext_y, 0);
        wait_done();

        rdy_mode = 1;
        for (int s = 0; s < 30; s++) begin
            for (int k = 0; k < NUM_PT; k++) begin
                rx[k] = rnd_coord();
                ry[k] = rnd_coord();
            end
            send_set(rx, ry, 1);
            wait_done();
        end
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        check("final_queue_empty", qx.size(), 0);
        check("final_in_ready", int'(in_ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1);
    end
endmodule
